// File: rtl/knn_ctrl.sv
// K-nearest-neighbour query controller: streams data points into a distance
// datapath, then scans the returned distances into a sorted top-K list.
module knn_ctrl #(
  parameter int NUM_PTS = 16,
  parameter int K       = 4,
  parameter int DP_LAT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       test_pt,
  output logic              busy,
  output logic              done,
  output logic              pt_rd,
  output logic [7:0]        pt_addr,
  input  logic [31:0]       pt_data,
  output logic [31:0]       dp_test_pt,
  output logic [31:0]       dp_data_pt,
  output logic              dp_start,
  output logic              dp_sample,
  output logic [7:0]        dp_addr,
  input  logic [31:0]       dp_dist,
  output logic [8*K-1:0]    nn_idx,
  output logic [32*K-1:0]   nn_dist
);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, SCAN, DONE} state_t;

  localparam logic [15:0] NP       = 16'(NUM_PTS);
  localparam logic [15:0] LAT      = 16'(DP_LAT);
  localparam logic [15:0] RUN_LAST = 16'(NUM_PTS + DP_LAT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        data_sel;
  logic [7:0]  idx_q  [K];
  logic [31:0] dist_q [K];
  logic [7:0]  idx_d  [K];
  logic [31:0] dist_d [K];
  logic [7:0]  cons_idx;

  assign dp_data_pt = data_sel ? pt_data : '0;
  // Distance consumed in SCAN cycle cnt belongs to the index issued one cycle earlier.
  assign cons_idx   = 8'(cnt - 16'd1);

  // Insertion into the sorted list: lt is a thermometer code (list is ascending),
  // so the slot where it first goes high takes the new entry, higher ones shift up.
  always_comb begin
    logic [K-1:0] lt;
    for (int unsigned s = 0; s < K; s++) begin
      lt[s]     = dp_dist < dist_q[s];
      idx_d[s]  = idx_q[s];
      dist_d[s] = dist_q[s];
    end
    if (lt[0]) begin
      idx_d[0]  = cons_idx;
      dist_d[0] = dp_dist;
    end
    for (int unsigned s = 1; s < K; s++) begin
      if (lt[s]) begin
        if (lt[s-1]) begin
          idx_d[s]  = idx_q[s-1];
          dist_d[s] = dist_q[s-1];
        end else begin
          idx_d[s]  = cons_idx;
          dist_d[s] = dp_dist;
        end
      end
    end
  end

  for (genvar s = 0; s < K; s++) begin : g_pack
    assign nn_idx[8*s +: 8]   = idx_q[s];
    assign nn_dist[32*s +: 32] = dist_q[s];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pt_rd      <= 1'b0;
      pt_addr    <= '0;
      dp_start   <= 1'b0;
      dp_sample  <= 1'b0;
      dp_addr    <= '0;
      dp_test_pt <= '0;
      data_sel   <= 1'b0;
      for (int unsigned s = 0; s < K; s++) begin
        idx_q[s]  <= '1;
        dist_q[s] <= '1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= PRIME;
            busy       <= 1'b1;
            dp_test_pt <= test_pt;
            pt_rd      <= 1'b1;
            pt_addr    <= '0;
            for (int unsigned s = 0; s < K; s++) begin
              idx_q[s]  <= '1;
              dist_q[s] <= '1;
            end
          end
        end
        PRIME: begin
          state    <= RUN;
          cnt      <= '0;
          dp_start <= 1'b1;
          data_sel <= 1'b1;
          pt_rd    <= (NUM_PTS > 1);
          pt_addr  <= (NUM_PTS > 1) ? 8'd1 : 8'd0;
        end
        RUN: begin
          if (cnt == RUN_LAST) begin
            state     <= SCAN;
            cnt       <= '0;
            dp_start  <= 1'b0;
            data_sel  <= 1'b0;
            pt_rd     <= 1'b0;
            dp_sample <= 1'b1;
            dp_addr   <= 8'(LAT);
          end else begin
            cnt      <= cnt + 16'd1;
            data_sel <= (cnt + 16'd1 < NP);
            if (cnt + 16'd2 < NP) begin
              pt_rd   <= 1'b1;
              pt_addr <= 8'(cnt + 16'd2);
            end else begin
              pt_rd   <= 1'b0;
            end
          end
        end
        SCAN: begin
          if (cnt != '0) begin
            for (int unsigned s = 0; s < K; s++) begin
              idx_q[s]  <= idx_d[s];
              dist_q[s] <= dist_d[s];
            end
          end
          if (cnt == NP) begin
            state <= DONE;
            done  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
            if (cnt + 16'd1 < NP) begin
              dp_addr <= 8'(cnt + 16'd1 + LAT);
            end else begin
              dp_sample <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_ctrl.sv
// Directed bench for knn_ctrl with a behavioural point memory and distance datapath.
module tb_knn_ctrl;
  localparam int NUM_PTS = 16;
  localparam int K       = 4;
  localparam int DP_LAT  = 3;

  logic            clk = 1'b0;
  logic            rst, start;
  logic [31:0]     test_pt;
  logic            busy, done, pt_rd, dp_start, dp_sample;
  logic [7:0]      pt_addr, dp_addr;
  logic [31:0]     pt_data = '0, dp_dist = '0;
  logic [31:0]     dp_test_pt, dp_data_pt;
  logic [8*K-1:0]  nn_idx;
  logic [32*K-1:0] nn_dist;

  int n_cmp, n_err;
  int n_pt, n_ds, n_smp, n_done;
  logic [7:0]  pt_log [32];
  logic [7:0]  dp_log [32];
  logic [31:0] pmem [256];
  logic [31:0] dmem [256];
  logic [7:0]  dpk = '0;

  knn_ctrl #(.NUM_PTS(NUM_PTS), .K(K), .DP_LAT(DP_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .test_pt(test_pt),
    .busy(busy), .done(done), .pt_rd(pt_rd), .pt_addr(pt_addr), .pt_data(pt_data),
    .dp_test_pt(dp_test_pt), .dp_data_pt(dp_data_pt), .dp_start(dp_start),
    .dp_sample(dp_sample), .dp_addr(dp_addr), .dp_dist(dp_dist),
    .nn_idx(nn_idx), .nn_dist(nn_dist)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sqd(input logic [31:0] a, input logic [31:0] b);
    logic signed [16:0] dx, dy;
    logic signed [33:0] px, py;
    dx = $signed({a[31], a[31:16]}) - $signed({b[31], b[31:16]});
    dy = $signed({a[15], a[15:0]}) - $signed({b[15], b[15:0]});
    px = dx * dx;
    py = dy * dy;
    return px[31:0] + py[31:0];
  endfunction

  // Point memory (1-cycle read) and datapath: point j lands at address j+DP_LAT.
  always @(posedge clk) begin
    if (pt_rd) pt_data <= pmem[pt_addr];
    if (dp_start) begin
      dmem[dpk + 8'(DP_LAT)] <= sqd(dp_test_pt, dp_data_pt);
      dpk <= dpk + 8'd1;
    end else begin
      dpk <= '0;
    end
    if (dp_sample) dp_dist <= dmem[dp_addr];
  end

  always @(negedge clk) begin
    if (pt_rd) begin
      if (n_pt < 32) pt_log[n_pt] = pt_addr;
      n_pt++;
    end
    if (dp_start) n_ds++;
    if (dp_sample) begin
      if (n_smp < 32) dp_log[n_smp] = dp_addr;
      n_smp++;
    end
    if (done) n_done++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctl"}, 128'({busy, done, pt_rd, dp_start, dp_sample}), 128'(0));
    check({tag, "_addr"}, 128'({pt_addr, dp_addr}), 128'(0));
    check({tag, "_dp"}, 128'({dp_test_pt, dp_data_pt}), 128'(0));
    check({tag, "_idx"}, 128'(nn_idx), 128'(32'hFFFF_FFFF));
    check({tag, "_dist"}, 128'(nn_dist), {128{1'b1}});
  endtask

  task automatic run_query(input logic [31:0] tp, input bit noise, input int abort_at);
    int lat;
    @(posedge clk); #1;
    n_pt = 0; n_ds = 0; n_smp = 0; n_done = 0;
    start = 1'b1; test_pt = tp; lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      start = noise && (lat == 5 || lat == 25);
      if (noise && lat == 5) test_pt = 32'h1234_5678;
      if (lat == 1) begin
        check("clr_idx", 128'(nn_idx), 128'(32'hFFFF_FFFF));
        check("clr_dist", 128'(nn_dist), {128{1'b1}});
      end
      if (lat == abort_at) begin
        #3 rst = 1'b1;
        #1 check_reset_vals("abort");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        return;
      end
      if (done) break;
    end
    start = 1'b0;
    check("latency", 128'(lat), 128'(2*NUM_PTS + DP_LAT + 3));
  endtask

  task automatic check_result(input string tag, input logic [31:0] e_idx, input logic [127:0] e_dist);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_idx"}, 128'(nn_idx), 128'(e_idx));
    check({tag, "_dist"}, 128'(nn_dist), e_dist);
    check({tag, "_done_cnt"}, 128'(n_done), 128'(1));
    check({tag, "_idle"}, 128'(busy), 128'(0));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; test_pt = '0;
    n_cmp = 0; n_err = 0; n_pt = 0; n_ds = 0; n_smp = 0; n_done = 0;
    #2 rst = 1'b1;
    #1 check_reset_vals("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic sort plus handshake sequencing.
    for (int j = 0; j < 256; j++) pmem[j] = {16'(j), 16'h0};
    run_query(32'h0, 1'b0, 0);
    check_result("basic", 32'h0302_0100, {32'd9, 32'd4, 32'd1, 32'd0});
    check("pt_rd_cnt", 128'(n_pt), 128'(NUM_PTS));
    for (int i = 0; i < NUM_PTS; i++) check("pt_addr_seq", 128'(pt_log[i]), 128'(i));
    check("dp_start_cnt", 128'(n_ds), 128'(NUM_PTS + DP_LAT));
    check("dp_sample_cnt", 128'(n_smp), 128'(NUM_PTS));
    for (int i = 0; i < NUM_PTS; i++) check("dp_addr_seq", 128'(dp_log[i]), 128'(i + DP_LAT));
    repeat (5) @(posedge clk);
    #1 check("hold_idx", 128'(nn_idx), 128'(32'h0302_0100));

    for (int j = 0; j < NUM_PTS; j++) pmem[j] = {16'(15 - j), 16'h0};
    run_query(32'h0, 1'b0, 0);
    check_result("reverse", 32'h0C0D_0E0F, {32'd9, 32'd4, 32'd1, 32'd0});

    for (int j = 0; j < NUM_PTS; j++) pmem[j] = {16'd3, 16'd4};
    run_query(32'h0, 1'b0, 0);
    check_result("ties", 32'h0302_0100, {32'd25, 32'd25, 32'd25, 32'd25});

    for (int j = 0; j < NUM_PTS; j++) pmem[j] = (j == 5) ? {16'hFFFE, 16'hFFFF} : {16'd100, 16'd100};
    run_query({16'hFFFE, 16'hFFFE}, 1'b0, 0);
    check_result("negative", 32'h0201_0005, {32'd20808, 32'd20808, 32'd20808, 32'd1});

    // Start pulses while busy must neither retarget nor queue a query.
    for (int j = 0; j < NUM_PTS; j++) pmem[j] = {16'(j), 16'h0};
    run_query(32'h0, 1'b1, 0);
    check_result("busy_start", 32'h0302_0100, {32'd9, 32'd4, 32'd1, 32'd0});
    check("busy_test_pt", 128'(dp_test_pt), 128'(0));

    run_query(32'h0, 1'b0, 8);
    repeat (50) @(posedge clk);
    #1 check("abort_no_done", 128'(n_done), 128'(0));
    check("abort_idle", 128'({busy, dp_start, dp_sample, pt_rd}), 128'(0));
    run_query(32'h0, 1'b0, 0);
    check_result("restart", 32'h0302_0100, {32'd9, 32'd4, 32'd1, 32'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/knn_ctrl.md
KNN_CTRL -- requirements
Module: knn_ctrl

Interface
REQ-001 SHALL have parameter NUM_PTS, default 16, number of data points per query (1..253).
REQ-002 SHALL have parameter K, default 4, number of nearest neighbours kept (1..NUM_PTS).
REQ-003 SHALL have parameter DP_LAT, default 3: the distance for data point j lands at datapath address j+DP_LAT.
REQ-004 SHALL have the following ports, one per line: name  direction  width  meaning.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  query request, sampled in IDLE only.
- test_pt  in  32  query point: X in [31:16], Y in [15:0].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when results are final.
- pt_rd  out  1  data-point memory read strobe.
- pt_addr  out  8  data-point memory address.
- pt_data  in  32  memory read data, valid the cycle after pt_rd.
- dp_test_pt  out  32  test point to the datapath.
- dp_data_pt  out  32  data point to the datapath.
- dp_start  out  1  datapath run enable.
- dp_sample  out  1  datapath distance-read strobe.
- dp_addr  out  8  datapath distance-read address.
- dp_dist  in  32  unsigned distance, valid the cycle after dp_sample.
- nn_idx  out  8*K  slot s in bits [8s+7:8s]; point indices sorted ascending by distance.
- nn_dist  out  32*K  slot s in bits [32s+31:32s]; matching distances.

Function
REQ-005 SHALL implement FSM states IDLE, PRIME, RUN, SCAN and DONE.
REQ-006 IDLE: start=1 SHALL latch test_pt into dp_test_pt, set all nn_dist slots to 32'hFFFFFFFF and all nn_idx slots to 8'hFF, and go to PRIME.
REQ-007 PRIME, 1 cycle: pt_rd=1, pt_addr=0, dp_start=0; then go to RUN.
REQ-008 RUN, exactly NUM_PTS+DP_LAT cycles, run counter c=0.. : dp_start=1.
- c<NUM_PTS: dp_data_pt=pt_data, i.e. point c.
- c>=NUM_PTS: dp_data_pt=0.
- c<NUM_PTS-1: pt_rd=1, pt_addr=c+1.
- otherwise: pt_rd=0.
REQ-009 After RUN, SHALL go to SCAN with dp_start=0; dp_start SHALL never be high outside RUN.
REQ-010 SCAN issue cycles j=0..NUM_PTS-1: dp_sample=1, dp_addr=j+DP_LAT.
REQ-011 SCAN SHALL last NUM_PTS+1 cycles; the result returned for index j is consumed in the cycle after it is issued.
REQ-012 Top-K update for index j, distance d:
- find the lowest slot s with d < nn_dist[s] (strict);
- shift slots s..K-2 up by one and write (j,d) into slot s;
- if no such slot exists, the list is unchanged.
REQ-013 Ties SHALL keep the lower index in the lower slot.
REQ-014 The top-K update SHALL complete in one cycle per returned distance.
REQ-015 After the final SCAN cycle, SHALL enter DONE for 1 cycle with done=1, then return to IDLE.
REQ-016 The total query latency from the start-accept edge to done=1 SHALL be 2*NUM_PTS+DP_LAT+3 cycles.
REQ-017 start while busy=1 SHALL be ignored; no queueing.
REQ-018 nn_idx and nn_dist SHALL hold their values from DONE until the next accepted start.
REQ-019 Distances SHALL be compared as unsigned 32-bit values; 32'hFFFFFFFF SHALL never displace the initial sentinel in a slot.
REQ-020 pt_addr and dp_addr SHALL never exceed NUM_PTS-1 and NUM_PTS-1+DP_LAT respectively; no wrap.

Reset
REQ-021 While rst=1, and asynchronously on assertion, the block SHALL enter IDLE.
REQ-022 During reset, busy, done, pt_rd, dp_start and dp_sample SHALL be 0.
REQ-023 During reset, pt_addr, dp_addr, dp_test_pt and dp_data_pt SHALL be 0.
REQ-024 During reset, nn_dist slots SHALL be 32'hFFFFFFFF and nn_idx slots 8'hFF.
REQ-025 Reset mid-query SHALL abort the query with no done pulse; the next start SHALL run a full query.

Verification
REQ-026 Basic sort: NUM_PTS=16, K=4, test_pt=0, point j=(j,0); start -> done at cycle 38; nn_idx={0,1,2,3}; nn_dist={0,1,4,9}.
REQ-027 Reverse order: point j=(15-j,0) -> nn_idx={15,14,13,12}; nn_dist={0,1,4,9}.
REQ-028 Ties: all points equal to (3,4), test_pt=0 -> nn_idx={0,1,2,3}; nn_dist all 25.
REQ-029 Protocol: check pt_addr 0..15, one per cycle; dp_start high exactly 19 cycles; dp_addr 3..18; start pulses during busy have no effect.
REQ-030 Reset abort: assert rst during RUN -> all outputs at reset values, no done; a restarted query matches REQ-026.
REQ-031 Negative coordinates: test_pt=(-2,-2), point 5=(-2,-1), others (100,100) -> nn_idx[0]=5, nn_dist[0]=1.
